// File: rtl/ifc_value_pkg.sv
// ifc_value_pkg
// Shared definitions for the single-value channel: update-policy encodings,
// the value type, the default stability threshold and a parity helper.
package ifc_value_pkg;

   localparam int MODE_GATED   = 0;
   localparam int MODE_FOLLOW1 = 1;
   localparam int MODE_FOLLOW2 = 2;

   typedef logic signed [31:0] value_t;

   localparam int STABLE_CYCLES_DEF = 8;
   // Wide enough for the largest legal STABLE_CYCLES (255).
   localparam int STABLE_CNT_W      = 8;

   function automatic logic even_parity(input value_t v);
      return ^v;
   endfunction

endpackage

// File: rtl/ifc_stable_tracker.sv
// ifc_stable_tracker
// Tracks how long the channel value has been unchanged and how many times it
// has changed.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   changed_i       one-cycle pulse: value just took a new value
//   valid_i         value has been loaded since reset
//   stable_o        value unchanged for STABLE_CYCLES cycles
//   update_cnt_o    saturating count of changes
module ifc_stable_tracker
   import ifc_value_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             changed_i,
   input  logic             valid_i,
   output logic             stable_o,
   output logic [CNT_W-1:0] update_cnt_o
);

   localparam logic [STABLE_CNT_W-1:0] STAB_TC = STABLE_CNT_W'(STABLE_CYCLES);

   logic [STABLE_CNT_W-1:0] stab_q, stab_d;
   logic [CNT_W-1:0]        upd_q, upd_d;

   always_comb begin
      stab_d = stab_q;
      upd_d  = upd_q;
      if (changed_i) begin
         stab_d = '0;
      end else if (valid_i && (stab_q != STAB_TC)) begin
         stab_d = stab_q + 1'b1;
      end
      if (changed_i && (upd_q != '1)) begin
         upd_d = upd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_q <= '0;
         upd_q  <= '0;
      end else begin
         stab_q <= stab_d;
         upd_q  <= upd_d;
      end
   end

   assign stable_o     = valid_i && (stab_q == STAB_TC);
   assign update_cnt_o = upd_q;

endmodule

// File: rtl/ifc_value_channel.sv
// ifc_value_channel
// Single 32-bit signed value channel from a producer to its parent, with
// valid / change / stability status and a compile-time MODE tag.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   wr_en           write strobe (MODE 0 only)
//   wr_data         producer value
//   mode_o          constant MODE[1:0]
//   value_o         held value
//   valid_o         value loaded at least once since reset
//   changed_o       one-cycle pulse on a new, different value (or first load)
//   update_cnt_o    saturating change count
//   stable_o        value unchanged for STABLE_CYCLES cycles
// Optional (IFC_VALUE_PARITY_EN defined):
//   parity_o        even parity of value_o, registered with it
//   chk_parity_i    parity expected by the consumer
//   parity_err_o    sticky mismatch flag, cleared only by rst_n
module ifc_value_channel
   import ifc_value_pkg::*;
#(
   parameter int MODE          = MODE_GATED,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  value_t           wr_data,
   output logic [1:0]       mode_o,
   output value_t           value_o,
   output logic             valid_o,
   output logic             changed_o,
   output logic [CNT_W-1:0] update_cnt_o,
   output logic             stable_o
`ifdef IFC_VALUE_PARITY_EN
   ,
   output logic             parity_o,
   input  logic             chk_parity_i,
   output logic             parity_err_o
`endif
);

   generate
      if (MODE < MODE_GATED || MODE > MODE_FOLLOW2) begin : g_bad_mode
         $error("ifc_value_channel: MODE must be 0, 1 or 2");
      end
      if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
         $error("ifc_value_channel: STABLE_CYCLES must be in 1..255");
      end
   endgenerate

   localparam logic [1:0] MODE_TAG = 2'(MODE);

   value_t value_q, value_d;
   value_t stage_q, stage_d;
   value_t load_val;
   logic   stage_vld_q, stage_vld_d;
   logic   valid_q, valid_d;
   logic   changed_q, changed_d;
   logic   load;

   always_comb begin
      stage_d     = stage_q;
      stage_vld_d = stage_vld_q;
      load        = 1'b0;
      load_val    = value_q;
      case (MODE)
         MODE_GATED: begin
            load     = wr_en;
            load_val = wr_data;
         end
         MODE_FOLLOW1: begin
            load     = 1'b1;
            load_val = wr_data;
         end
         default: begin
            // The output only counts as loaded once the stage holds real data,
            // so valid rises on the second edge after reset.
            stage_d     = wr_data;
            stage_vld_d = 1'b1;
            load        = stage_vld_q;
            load_val    = stage_q;
         end
      endcase
      value_d   = load ? load_val : value_q;
      valid_d   = valid_q | load;
      // The first load always pulses, even when it loads 0.
      changed_d = load && (!valid_q || (load_val != value_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q     <= '0;
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
         valid_q     <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         value_q     <= value_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         valid_q     <= valid_d;
         changed_q   <= changed_d;
      end
   end

   ifc_stable_tracker #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .changed_i    (changed_q),
      .valid_i      (valid_q),
      .stable_o     (stable_o),
      .update_cnt_o (update_cnt_o)
   );

   assign mode_o    = MODE_TAG;
   assign value_o   = value_q;
   assign valid_o   = valid_q;
   assign changed_o = changed_q;

`ifdef IFC_VALUE_PARITY_EN
   logic parity_q, parity_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         parity_q <= even_parity(value_d);
         if (chk_parity_i != parity_q) begin
            parity_err_q <= 1'b1;
         end
      end
   end

   assign parity_o     = parity_q;
   assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_ifc_value_channel.sv
module tb_ifc_value_channel;
   import ifc_value_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // MODE 0 instance
   logic       rst0 = 1'b0, we0 = 1'b0;
   value_t     d0 = '0, v0;
   logic [1:0] m0;
   logic       vl0, ch0, st0;
   logic [15:0] c0;
   // MODE 1 instance
   logic       rst1 = 1'b0, we1 = 1'b0;
   value_t     d1 = '0, v1;
   logic [1:0] m1;
   logic       vl1, ch1, st1;
   logic [15:0] c1;
   // MODE 2 instance
   logic       rst2 = 1'b0, we2 = 1'b0;
   value_t     d2 = '0, v2;
   logic [1:0] m2;
   logic       vl2, ch2, st2;
   logic [15:0] c2;
`ifdef IFC_VALUE_PARITY_EN
   logic chk0 = 1'b0, chk1 = 1'b0, chk2 = 1'b0;
   logic par0, par1, par2, perr0, perr1, perr2;
`endif

   ifc_value_channel #(.MODE(0), .STABLE_CYCLES(8), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst0), .wr_en(we0), .wr_data(d0), .mode_o(m0),
      .value_o(v0), .valid_o(vl0), .changed_o(ch0), .update_cnt_o(c0),
      .stable_o(st0)
`ifdef IFC_VALUE_PARITY_EN
      , .parity_o(par0), .chk_parity_i(chk0), .parity_err_o(perr0)
`endif
   );

   ifc_value_channel #(.MODE(1), .STABLE_CYCLES(8), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst1), .wr_en(we1), .wr_data(d1), .mode_o(m1),
      .value_o(v1), .valid_o(vl1), .changed_o(ch1), .update_cnt_o(c1),
      .stable_o(st1)
`ifdef IFC_VALUE_PARITY_EN
      , .parity_o(par1), .chk_parity_i(chk1), .parity_err_o(perr1)
`endif
   );

   ifc_value_channel #(.MODE(2), .STABLE_CYCLES(8), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst2), .wr_en(we2), .wr_data(d2), .mode_o(m2),
      .value_o(v2), .valid_o(vl2), .changed_o(ch2), .update_cnt_o(c2),
      .stable_o(st2)
`ifdef IFC_VALUE_PARITY_EN
      , .parity_o(par2), .chk_parity_i(chk2), .parity_err_o(perr2)
`endif
   );

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic expect_v(input string tag, input longint e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [63:0] obs);
      exp_t x;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard_underflow: observed %0d with no expected value", obs);
      end else begin
         x = sb.pop_front();
         n_cmp++;
         assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", x.tag, $signed(obs), $signed(x.exp));
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic seen_stable;

   initial begin
      step(2);

      // ---- MODE 1, wr_data held at 4 ----
      d1 = 4;
      expect_v("m1_rst_value", 0);   check(64'(v1));
      expect_v("m1_rst_valid", 0);   check(64'(vl1));
      expect_v("m1_rst_stable", 0);  check(64'(st1));
      expect_v("m1_rst_cnt", 0);     check(64'(c1));
      expect_v("m1_mode", 1);        check(64'(m1));
      rst1 = 1'b1;
      expect_v("m1_e1_value", 4);
      expect_v("m1_e1_valid", 1);
      expect_v("m1_e1_changed", 1);
      expect_v("m1_e1_cnt", 0);
      step(1);
      check(64'(v1)); check(64'(vl1)); check(64'(ch1)); check(64'(c1));
      expect_v("m1_e2_changed", 0);
      expect_v("m1_e2_cnt", 1);
      step(1);
      check(64'(ch1)); check(64'(c1));
      expect_v("m1_c20_stable", 1);
      expect_v("m1_c20_value", 4);
      expect_v("m1_c20_cnt", 1);
      expect_v("m1_c20_mode", 1);
      step(18);
      check(64'(st1)); check(64'(v1)); check(64'(c1)); check(64'(m1));

      // ---- MODE 1, async reset mid-cycle after 9 is stable ----
      d1 = 9;
      expect_v("m1_9_stable", 1);
      expect_v("m1_9_value", 9);
      step(12);
      check(64'(st1)); check(64'(v1));
      #3 rst1 = 1'b0;
      #1;
      expect_v("m1_async_value", 0);   check(64'(v1));
      expect_v("m1_async_valid", 0);   check(64'(vl1));
      expect_v("m1_async_changed", 0); check(64'(ch1));
      expect_v("m1_async_cnt", 0);     check(64'(c1));
      expect_v("m1_async_stable", 0);  check(64'(st1));
      #1 rst1 = 1'b1;
      expect_v("m1_rel_valid", 1);
      expect_v("m1_rel_value", 9);
      expect_v("m1_rel_changed", 1);
      step(1);
      check(64'(vl1)); check(64'(v1)); check(64'(ch1));

      // ---- MODE 2, wr_data held at 5 ----
      d2 = 5;
      expect_v("m2_mode", 2); check(64'(m2));
      rst2 = 1'b1;
      expect_v("m2_e1_value", 0);
      expect_v("m2_e1_valid", 0);
      step(1);
      check(64'(v2)); check(64'(vl2));
      expect_v("m2_e2_value", 5);
      expect_v("m2_e2_valid", 1);
      expect_v("m2_e2_changed", 1);
      step(1);
      check(64'(v2)); check(64'(vl2)); check(64'(ch2));
      expect_v("m2_c20_value", 5);
      expect_v("m2_c20_cnt", 1);
      expect_v("m2_c20_mode", 2);
      step(18);
      check(64'(v2)); check(64'(c2)); check(64'(m2));

      // ---- MODE 0, gated writes ----
      d0 = 7;
      rst0 = 1'b1;
      expect_v("m0_idle_valid", 0);
      expect_v("m0_idle_value", 0);
      expect_v("m0_idle_changed", 0);
      step(5);
      check(64'(vl0)); check(64'(v0)); check(64'(ch0));
      we0 = 1'b1;
      expect_v("m0_p1_value", 7);
      expect_v("m0_p1_valid", 1);
      expect_v("m0_p1_changed", 1);
      step(1);
      check(64'(v0)); check(64'(vl0)); check(64'(ch0));
      we0 = 1'b0;
      d0 = -3;
      expect_v("m0_hold_value", 7);
      expect_v("m0_hold_changed", 0);
      expect_v("m0_hold_cnt", 1);
      step(1);
      check(64'(v0)); check(64'(ch0)); check(64'(c0));
      d0 = 7;
      we0 = 1'b1;
      expect_v("m0_p2_changed", 0);
      expect_v("m0_p2_valid", 1);
      step(1);
      check(64'(ch0)); check(64'(vl0));
      we0 = 1'b0;
      expect_v("m0_p2_cnt", 1);
      expect_v("m0_p2_value", 7);
      step(1);
      check(64'(c0)); check(64'(v0));
      d0 = -3;
      we0 = 1'b1;
      step(1);
      we0 = 1'b0;
      expect_v("m0_neg_value", -3);
      expect_v("m0_neg_cnt", 2);
      step(1);
      check(64'(v0)); check(64'(c0));

      // ---- MODE 1, toggling 1/2 for 70000 cycles: counter saturates ----
      rst1 = 1'b0;
      d1 = 1;
      step(1);
      rst1 = 1'b1;
      seen_stable = 1'b0;
      expect_v("tog_sat_cnt", 65535);
      expect_v("tog_never_stable", 0);
      for (int i = 0; i < 70000; i++) begin
         d1 = ((i % 2) == 0) ? 32'sd1 : 32'sd2;
         step(1);
         if (st1) seen_stable = 1'b1;
      end
      check(64'(c1)); check(64'(seen_stable));

`ifdef IFC_VALUE_PARITY_EN
      // ---- parity: value 3 has even parity 0, consumer claims 1 ----
      rst1 = 1'b0;
      d1 = 3;
      chk1 = 1'b1;
      step(1);
      expect_v("par_rst_err", 0); check(64'(perr1));
      rst1 = 1'b1;
      expect_v("par_value", 3);
      expect_v("par_parity", 0);
      expect_v("par_err_set", 1);
      step(1);
      check(64'(v1)); check(64'(par1)); check(64'(perr1));
      chk1 = 1'b0;
      expect_v("par_err_sticky", 1);
      step(5);
      check(64'(perr1));
      rst1 = 1'b0;
      #1;
      expect_v("par_err_cleared", 0); check(64'(perr1));
`endif

      expect_v("sb_drained", 0);
      check(64'(sb.size() - 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
